// File: rtl/adder_mul_sequencer.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier controller.
// It has no adder of its own. It drives one external WIDTH-bit adder through
// ADD_A/ADD_B and reads the combinational sum back on ADD_SUM, one step per cycle.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for START; adder operands held at zero
// S_RUN  | WIDTH shift-and-add steps, one per clock; BUSY high
// S_DONE | single-cycle DONE pulse; PRODUCT valid; START accepted again
module adder_mul_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               CLOCK,
   input  logic               RESET,
   input  logic               START,
   input  logic [WIDTH-1:0]   OPA,
   input  logic [WIDTH-1:0]   OPB,
   output logic               BUSY,
   output logic               DONE,
   output logic [2*WIDTH-1:0] PRODUCT,
   output logic [WIDTH-1:0]   ADD_A,
   output logic [WIDTH-1:0]   ADD_B,
   input  logic [WIDTH-1:0]   ADD_SUM
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic [WIDTH-1:0]   mcand;
   logic [CNT_W-1:0]   cnt;

   logic               accept;
   logic               last_step;
   logic               carry;
   logic [WIDTH-1:0]   hi_next;
   logic [WIDTH-1:0]   lo_next;

   // A new operation may begin from IDLE or straight out of DONE; never while running.
   assign accept    = START && (state != S_RUN);
   assign last_step = (cnt == CNT_W'(WIDTH - 1));

   // The adder wraps at WIDTH bits. Because ADD_B fits in WIDTH bits, the sum has
   // wrapped exactly when it is smaller than HI, so that compare recovers the lost carry.
   always_comb begin
      carry   = (ADD_SUM < hi);
      hi_next = {carry, ADD_SUM[WIDTH-1:1]};
      lo_next = {ADD_SUM[0], lo[WIDTH-1:1]};
   end

   // State register.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and status/adder outputs. The adder operands depend on registers only.
   always_comb begin
      state_next = state;
      BUSY       = 1'b0;
      DONE       = 1'b0;
      ADD_A      = '0;
      ADD_B      = '0;
      case (state)
         S_IDLE: begin
            if (accept) state_next = S_RUN;
         end
         S_RUN: begin
            BUSY  = 1'b1;
            ADD_A = hi;
            ADD_B = lo[0] ? mcand : '0;
            if (last_step) state_next = S_DONE;
         end
         S_DONE: begin
            DONE       = 1'b1;
            state_next = accept ? S_RUN : S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Datapath: load operands on accept, then shift one partial-product step per RUN cycle.
   // PRODUCT changes only on the final step, so it holds the previous result during a run.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         hi      <= '0;
         lo      <= '0;
         mcand   <= '0;
         cnt     <= '0;
         PRODUCT <= '0;
      end else if (accept) begin
         mcand <= OPA;
         lo    <= OPB;
         hi    <= '0;
         cnt   <= '0;
      end else if (state == S_RUN) begin
         hi  <= hi_next;
         lo  <= lo_next;
         cnt <= cnt + CNT_W'(1);
         if (last_step) PRODUCT <= {hi_next, lo_next};
      end
   end

endmodule
